// File: rtl/boot_pkg.sv
// Shared boot-path definitions: UART receiver states, bit-timing helper and
// the character set understood by the boot hex parser.
package boot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned clocks_per_bit(input int unsigned clk_frequency,
                                                 input int unsigned baud_rate);
    return (clk_frequency + baud_rate / 2) / baud_rate;
  endfunction

  localparam logic [7:0] CHAR_CR      = 8'h0D;
  localparam logic [7:0] CHAR_LF      = 8'h0A;
  localparam logic [7:0] CHAR_DIGIT_0 = 8'h30;
  localparam logic [7:0] CHAR_DIGIT_9 = 8'h39;
  localparam logic [7:0] CHAR_UPPER_A = 8'h41;
  localparam logic [7:0] CHAR_UPPER_F = 8'h46;
  localparam logic [7:0] CHAR_LOWER_A = 8'h61;
  localparam logic [7:0] CHAR_LOWER_F = 8'h66;

  function automatic logic is_hex_char(input logic [7:0] c);
    return ((c >= CHAR_DIGIT_0) && (c <= CHAR_DIGIT_9)) ||
           ((c >= CHAR_UPPER_A) && (c <= CHAR_UPPER_F)) ||
           ((c >= CHAR_LOWER_A) && (c <= CHAR_LOWER_F));
  endfunction

  // Nibble value of a hex character; non-hex characters map to 0.
  function automatic logic [3:0] hex_value(input logic [7:0] c);
    logic [7:0] v;
    v = 8'h00;
    if ((c >= CHAR_DIGIT_0) && (c <= CHAR_DIGIT_9)) begin
      v = c - CHAR_DIGIT_0;
    end else if ((c >= CHAR_UPPER_A) && (c <= CHAR_UPPER_F)) begin
      v = c - CHAR_UPPER_A + 8'd10;
    end else if ((c >= CHAR_LOWER_A) && (c <= CHAR_LOWER_F)) begin
      v = c - CHAR_LOWER_A + 8'd10;
    end
    return v[3:0];
  endfunction

endpackage

// File: rtl/boot_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; reset value is
// chosen per input so an idle line does not look like activity after reset.
module boot_sync_2ff #(
  parameter int               width       = 1,
  parameter logic [width-1:0] reset_value = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [width-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= reset_value;
      q    <= reset_value;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/boot_uart_rx.sv
// 8N1 UART receiver for the boot path: oversamples rx, centres on each bit
// and emits one-cycle out_valid or framing_error pulses per frame.
module boot_uart_rx
  import boot_pkg::*;
#(
  parameter int unsigned clk_frequency = 50_000_000,
  parameter int unsigned baud_rate     = 115200,
  parameter int unsigned char_width    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  out_valid,
  output logic [char_width-1:0] out_char,
  output logic                  framing_error,
  output logic                  busy
);

  localparam int unsigned D  = clocks_per_bit(clk_frequency, baud_rate);
  localparam int unsigned H  = D / 2;
  localparam int unsigned CW = (D < 2) ? 1 : $clog2(D);
  localparam int unsigned IW = $clog2(char_width + 1);

  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(D - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(char_width - 1);

  if (D < 4) begin : g_rate_check
    $error("boot_uart_rx: fewer than 4 clocks per bit is not supported");
  end

  logic rx_s;
  logic rx_d;

  boot_sync_2ff #(
    .width       (1),
    .reset_value (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_d <= 1'b1;
    else       rx_d <= rx_s;
  end

  uart_state_t               state;
  logic [CW-1:0]             cnt;
  logic [IW-1:0]             bit_idx;
  logic [char_width-1:0]     shift_reg;
  logic                      tick;

  assign tick = (cnt == '0);
  assign busy = (state != IDLE);

  // The free-running countdown reloads a full bit on every tick; states
  // override the load where the next sample point differs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      out_char      <= '0;
      out_valid     <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      out_valid     <= 1'b0;
      framing_error <= 1'b0;
      if (tick) cnt <= CNT_FULL;
      else      cnt <= cnt - 1'b1;

      unique case (state)
        IDLE: begin
          if (rx_d && !rx_s) begin
            cnt   <= CNT_HALF;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (!rx_s) begin
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shift_reg <= {rx_s, shift_reg[char_width-1:1]};
            bit_idx   <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (rx_s) begin
              out_char  <= shift_reg;
              out_valid <= 1'b1;
            end else begin
              framing_error <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_uart_rx.sv
// Directed bench for boot_uart_rx at D=16, H=8: frame timing, back-to-back
// frames, glitches, framing errors, mid-frame reset and baud offset.
module tb_boot_uart_rx;
  import boot_pkg::*;

  localparam int D     = 16;
  localparam int H     = 8;
  localparam int FRAME = 10 * D;
  localparam int LAT   = 2 + H + 9 * D + 1;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       out_valid;
  logic [7:0] out_char;
  logic       framing_error;
  logic       busy;

  int         cyc;
  int         n_checks;
  int         n_fail;
  int         valid_count;
  int         ferr_count;
  int         both_count;
  int         last_ferr_cyc;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         valid_cyc_q[$];

  boot_uart_rx #(
    .clk_frequency (1600),
    .baud_rate     (100),
    .char_width    (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx            (rx),
    .out_valid     (out_valid),
    .out_char      (out_char),
    .framing_error (framing_error),
    .busy          (busy)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // output monitor feeding the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        got_q.push_back(out_char);
        valid_cyc_q.push_back(cyc);
        valid_count++;
      end
      if (framing_error) begin
        ferr_count++;
        last_ferr_cyc = cyc;
      end
      if (out_valid && framing_error) both_count++;
    end
  end

  // driver tasks
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] ch, input int period_x100, input logic stop_val);
    logic [9:0] bits;
    bits = {stop_val, ch, 1'b0};
    for (int b = 0; b < 10; b++)
      hold(bits[b], ((b + 1) * period_x100) / 100 - (b * period_x100) / 100);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (framing_error !== 1'b0) begin n_fail++; $display("FAIL reset_framing_error: got %b expected 0", framing_error); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (out_char !== 8'h00) begin n_fail++; $display("FAIL reset_out_char: got %h expected 00", out_char); end
    reset = 1'b0;
    hold(1'b1, 10);
  endtask

  task automatic test_single_frame();
    int c0, v0, f0;
    got_q.delete(); valid_cyc_q.delete();
    v0 = valid_count; f0 = ferr_count;
    exp_q.push_back(CHAR_UPPER_A);
    c0 = cyc;
    send_frame(8'h41, 1600, 1'b1);
    hold(1'b1, 20);
    n_checks++; if (valid_count - v0 !== 1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", valid_count - v0); end
    if (got_q.size() > 0 && exp_q.size() > 0) begin
      n_checks++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL single_char: got %h expected %h", got_q[0], exp_q[0]); end
      n_checks++; if (valid_cyc_q[0] - c0 !== LAT) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", valid_cyc_q[0] - c0, LAT); end
    end
    exp_q.delete();
    n_checks++; if (ferr_count !== f0) begin n_fail++; $display("FAIL single_ferr: got %0d expected %0d", ferr_count, f0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int c0, v0;
    got_q.delete(); valid_cyc_q.delete();
    v0 = valid_count;
    exp_q.push_back(8'h31); exp_q.push_back(8'h46); exp_q.push_back(CHAR_CR);
    c0 = cyc;
    send_frame(8'h31, 1600, 1'b1);
    send_frame(8'h46, 1600, 1'b1);
    send_frame(8'h0D, 1600, 1'b1);
    hold(1'b1, 20);
    n_checks++; if (valid_count - v0 !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", valid_count - v0); end
    for (int i = 0; i < 3; i++) begin
      if (got_q.size() > i) begin
        n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_char%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        n_checks++; if (valid_cyc_q[i] - c0 !== LAT + i * FRAME) begin n_fail++; $display("FAIL b2b_time%0d: got %0d expected %0d", i, valid_cyc_q[i] - c0, LAT + i * FRAME); end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_glitch();
    int c0, v0, f0;
    v0 = valid_count; f0 = ferr_count;
    c0 = cyc;
    hold(1'b0, 3);
    rx = 1'b1;
    while (cyc < c0 + 10) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start: got %b expected 1", busy); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle_by_h1: got %b expected 0", busy); end
    @(posedge clk); #1;
    hold(1'b1, 200);
    n_checks++; if (valid_count !== v0) begin n_fail++; $display("FAIL glitch_valid: got %0d expected %0d", valid_count, v0); end
    n_checks++; if (ferr_count !== f0) begin n_fail++; $display("FAIL glitch_ferr: got %0d expected %0d", ferr_count, f0); end
  endtask

  task automatic test_framing_error();
    int c0, v0, f0;
    got_q.delete(); valid_cyc_q.delete();
    v0 = valid_count; f0 = ferr_count;
    c0 = cyc;
    send_frame(8'h55, 1600, 1'b0);
    hold(1'b0, 100);
    n_checks++; if (ferr_count - f0 !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d expected 1", ferr_count - f0); end
    n_checks++; if (last_ferr_cyc - c0 !== LAT) begin n_fail++; $display("FAIL ferr_latency: got %0d expected %0d", last_ferr_cyc - c0, LAT); end
    n_checks++; if (valid_count !== v0) begin n_fail++; $display("FAIL ferr_no_valid: got %0d expected %0d", valid_count, v0); end
    n_checks++; if (out_char !== CHAR_CR) begin n_fail++; $display("FAIL ferr_char_held: got %h expected 0d", out_char); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_break_idle: got %b expected 0", busy); end
    hold(1'b1, 20);
    exp_q.push_back(CHAR_DIGIT_0);
    send_frame(8'h30, 1600, 1'b1);
    hold(1'b1, 20);
    n_checks++; if (valid_count - v0 !== 1) begin n_fail++; $display("FAIL ferr_recover_count: got %0d expected 1", valid_count - v0); end
    if (got_q.size() > 0) begin
      n_checks++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL ferr_recover_char: got %h expected %h", got_q[0], exp_q[0]); end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] a5;
    int v0;
    got_q.delete(); valid_cyc_q.delete();
    a5 = 8'hA5;
    v0 = valid_count;
    hold(1'b0, D);
    for (int b = 0; b < 4; b++) hold(a5[b], D);
    hold(a5[4], D / 2);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
    reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    n_checks++; if (out_char !== 8'h00) begin n_fail++; $display("FAIL midreset_char: got %h expected 00", out_char); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b expected 0", out_valid); end
    n_checks++; if (framing_error !== 1'b0) begin n_fail++; $display("FAIL midreset_ferr: got %b expected 0", framing_error); end
    @(posedge clk); #1;
    rx    = 1'b1;
    reset = 1'b0;
    hold(1'b1, 200);
    n_checks++; if (valid_count !== v0) begin n_fail++; $display("FAIL midreset_discard: got %0d expected %0d", valid_count, v0); end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1600, 1'b1);
    hold(1'b1, 20);
    n_checks++; if (valid_count - v0 !== 1) begin n_fail++; $display("FAIL midreset_next_count: got %0d expected 1", valid_count - v0); end
    if (got_q.size() > 0) begin
      n_checks++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL midreset_next_char: got %h expected %h", got_q[0], exp_q[0]); end
    end
    exp_q.delete();
  endtask

  task automatic test_baud_error();
    int v0, f0;
    got_q.delete(); valid_cyc_q.delete();
    v0 = valid_count; f0 = ferr_count;
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    send_frame(8'h00, 1553, 1'b1);
    hold(1'b1, 20);
    send_frame(8'hFF, 1553, 1'b1);
    hold(1'b1, 20);
    n_checks++; if (valid_count - v0 !== 2) begin n_fail++; $display("FAIL baud_count: got %0d expected 2", valid_count - v0); end
    for (int i = 0; i < 2; i++) begin
      if (got_q.size() > i) begin
        n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL baud_char%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
    end
    n_checks++; if (ferr_count !== f0) begin n_fail++; $display("FAIL baud_ferr: got %0d expected %0d", ferr_count, f0); end
    exp_q.delete();
  endtask

  task automatic test_exclusive_pulses();
    n_checks++; if (both_count !== 0) begin n_fail++; $display("FAIL exclusive_pulses: got %0d overlaps expected 0", both_count); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    valid_count = 0; ferr_count = 0; both_count = 0; last_ferr_cyc = 0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_reset_mid_frame();
    test_baud_error();
    test_exclusive_pulses();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
